// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage architectural register file.
// Two write channels (E = ALU result, M = load result) and two combinational
// decode read ports with same-cycle write bypass. There is also a stored-value-only
// debug port and a saturating count of committed register updates.
module wb_regfile #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       W_dstE,
  input  logic [31:0]      W_valE,
  input  logic [4:0]       W_dstM,
  input  logic [31:0]      W_valM,
  input  logic [4:0]       d_srcA,
  input  logic [4:0]       d_srcB,
  output logic [31:0]      d_rvalA,
  output logic [31:0]      d_rvalB,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data,
  output logic [CNT_W-1:0] wr_count
);

  // Register 0 has no storage; it is hard-wired to zero in the read paths.
  logic [31:0] regs [1:31];

  logic             we_e;
  logic             we_m;
  logic [1:0]       upd_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Per-channel write enables and the number of distinct registers updated.
  always_comb begin
    we_e    = !rst && (W_dstE != 5'd0);
    we_m    = !rst && (W_dstM != 5'd0);
    upd_cnt = 2'd0;
    if (we_e && we_m && (W_dstE == W_dstM))
      upd_cnt = 2'd1;
    else
      upd_cnt = {1'b0, we_e} + {1'b0, we_m};
  end

  // Saturating counter update, computed one bit wider to catch overflow.
  always_comb begin
    cnt_sum  = {1'b0, wr_count} + (CNT_W+1)'(upd_cnt);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Storage and counter; the M write is issued last so it wins a same-register conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < 32; i++)
        regs[i] <= '0;
      wr_count <= '0;
    end else begin
      if (we_e)
        regs[W_dstE] <= W_valE;
      if (we_m)
        regs[W_dstM] <= W_valM;
      wr_count <= cnt_next;
    end
  end

  // Bypass priority is M before E, matching the write conflict rule, so a
  // bypassed value always equals what is stored on the next cycle.
  function automatic logic [31:0] read_port(input logic [4:0] src);
    if (rst || (src == 5'd0))
      return '0;
    else if ((BYPASS != 0) && (src == W_dstM))
      return W_valM;
    else if ((BYPASS != 0) && (src == W_dstE))
      return W_valE;
    else
      return regs[src];
  endfunction

  // Decode read ports.
  always_comb begin
    d_rvalA = read_port(d_srcA);
    d_rvalB = read_port(d_srcB);
  end

  // Debug port: stored value only, never bypassed.
  always_comb begin
    if (rst || (dbg_addr == 5'd0))
      dbg_data = '0;
    else
      dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile. u0 uses the defaults (BYPASS=1, CNT_W=32).
// u1 uses BYPASS=0 and CNT_W=3 to cover stored-value reads and counter saturation.
// Both instances share every input.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  W_dstE, W_dstM, d_srcA, d_srcB, dbg_addr;
  logic [31:0] W_valE, W_valM;

  logic [31:0] a0, b0, g0, a1, b1, g1;
  logic [31:0] c0;
  logic [2:0]  c1;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(a0), .d_rvalB(b0),
    .dbg_addr(dbg_addr), .dbg_data(g0), .wr_count(c0)
  );

  wb_regfile #(.BYPASS(0), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(a1), .d_rvalB(b1),
    .dbg_addr(dbg_addr), .dbg_data(g1), .wr_count(c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_write();
    W_dstE = 5'd0; W_valE = '0;
    W_dstM = 5'd0; W_valM = '0;
  endtask

  initial begin
    rst = 1'b1; no_write();
    d_srcA = 5'd0; d_srcB = 5'd0; dbg_addr = 5'd0;
    tick(); tick();

    // Outputs read 0 while reset is held.
    d_srcA = 5'd5; d_srcB = 5'd17; dbg_addr = 5'd31; #1;
    chk("rst_a0", a0, 32'h0); chk("rst_b0", b0, 32'h0); chk("rst_g0", g0, 32'h0);
    chk("rst_cnt0", c0, 32'h0); chk("rst_cnt1", {29'h0, c1}, 32'h0);

    rst = 1'b0; tick();
    // Every index reads 0 after reset.
    for (int i = 0; i < 32; i++) begin
      d_srcA = 5'(i); d_srcB = 5'(31 - i); dbg_addr = 5'(i); #1;
      chk("clr_a0", a0, 32'h0); chk("clr_b0", b0, 32'h0);
      chk("clr_a1", a1, 32'h0); chk("clr_g1", g1, 32'h0);
    end
    chk("clr_cnt0", c0, 32'h0);

    // Single E write: bypass on u0, stored value on u1, debug stays old.
    W_dstE = 5'd5; W_valE = 32'h1234_5678;
    d_srcB = 5'd5; dbg_addr = 5'd5; #1;
    chk("byp_b0", b0, 32'h1234_5678);
    chk("nobyp_b1", b1, 32'h0);
    chk("dbg_old0", g0, 32'h0);
    tick(); no_write();
    d_srcA = 5'd5; #1;
    chk("st5_a0", a0, 32'h1234_5678); chk("st5_a1", a1, 32'h1234_5678);
    chk("st5_g0", g0, 32'h1234_5678);
    chk("cnt0_1", c0, 32'd1); chk("cnt1_1", {29'h0, c1}, 32'd1);

    // Conflicting writes to r9: M wins, counted once.
    W_dstE = 5'd9; W_valE = 32'hAAAA_AAAA;
    W_dstM = 5'd9; W_valM = 32'h5555_5555;
    d_srcA = 5'd9; #1;
    chk("conf_byp_a0", a0, 32'h5555_5555);
    tick(); no_write(); #1;
    chk("conf_st_a0", a0, 32'h5555_5555); chk("conf_st_a1", a1, 32'h5555_5555);
    chk("cnt0_2", c0, 32'd2); chk("cnt1_2", {29'h0, c1}, 32'd2);

    // Distinct destinations 3 and 4 count twice; E bypass when M targets elsewhere.
    W_dstE = 5'd3; W_valE = 32'h0000_0033;
    W_dstM = 5'd4; W_valM = 32'h0000_0044;
    d_srcA = 5'd3; d_srcB = 5'd4; #1;
    chk("dual_byp_a0", a0, 32'h33); chk("dual_byp_b0", b0, 32'h44);
    tick(); no_write(); #1;
    chk("dual_a1", a1, 32'h33); chk("dual_b1", b1, 32'h44);
    chk("cnt0_4", c0, 32'd4); chk("cnt1_4", {29'h0, c1}, 32'd4);

    // Writes to r0 are dropped and not counted.
    W_dstE = 5'd0; W_valE = 32'hFFFF_FFFF;
    W_dstM = 5'd0; W_valM = 32'hFFFF_FFFF;
    d_srcA = 5'd0; #1;
    chk("r0_byp_a0", a0, 32'h0);
    tick(); no_write(); #1;
    chk("r0_a0", a0, 32'h0);
    chk("cnt0_r0", c0, 32'd4); chk("cnt1_r0", {29'h0, c1}, 32'd4);

    // Two single writes bring the counts to 6, then a dual write: u1 saturates at 7.
    W_dstE = 5'd1; W_valE = 32'h1; tick();
    W_dstE = 5'd2; W_valE = 32'h2; tick();
    no_write(); #1;
    chk("cnt1_6", {29'h0, c1}, 32'd6);
    W_dstE = 5'd10; W_valE = 32'hA; W_dstM = 5'd11; W_valM = 32'hB; tick();
    no_write(); #1;
    chk("cnt0_8", c0, 32'd8); chk("cnt1_sat_dual", {29'h0, c1}, 32'd7);
    W_dstE = 5'd12; W_valE = 32'hC; tick();
    no_write(); #1;
    chk("cnt1_stick", {29'h0, c1}, 32'd7); chk("cnt0_9", c0, 32'd9);

    // Load r7, then reset while a write to r7 is pending.
    W_dstM = 5'd7; W_valM = 32'h0000_00FF; tick();
    no_write();
    d_srcA = 5'd7; d_srcB = 5'd7; dbg_addr = 5'd7; #1;
    chk("r7_a1", a1, 32'hFF); chk("cnt0_10", c0, 32'd10);
    rst = 1'b1; W_dstM = 5'd7; W_valM = 32'hDEAD_BEEF; #1;
    chk("rstw_a0", a0, 32'h0); chk("rstw_b0", b0, 32'h0); chk("rstw_g0", g0, 32'h0);
    chk("rstw_a1", a1, 32'h0);
    tick(); #1;
    chk("rstw_cnt0", c0, 32'h0);
    rst = 1'b0; no_write(); #1;
    chk("post_a0", a0, 32'h0); chk("post_g1", g1, 32'h0);
    chk("post_cnt0", c0, 32'h0); chk("post_cnt1", {29'h0, c1}, 32'h0);

    // Nine single writes: u0 counts to 9, u1 sticks at 7.
    for (int i = 0; i < 9; i++) begin
      W_dstE = 5'(i + 1); W_valE = 32'(i + 100); tick();
    end
    no_write(); d_srcA = 5'd9; #1;
    chk("nine_cnt0", c0, 32'd9); chk("nine_cnt1", {29'h0, c1}, 32'd7);
    chk("nine_r9", a1, 32'd108);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file at the receiving end of the writeback stage.
- Consumes the two write channels the W pipeline register drives each cycle: the E channel (ALU result) and the M channel (memory load result).
- Serves two combinational read ports to the decode stage, with a same-cycle write-to-read bypass.
- Keeps a saturating count of committed register updates for debug and performance observation.

Parameters:
- BYPASS, 1: when 1, reads of a register being written this cycle return the incoming write data; when 0, reads return the stored value.
- CNT_W, 32: width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- W_dstE  input  5  E-channel destination register; 0 means no write.
- W_valE  input  32  E-channel write data.
- W_dstM  input  5  M-channel destination register; 0 means no write.
- W_valM  input  32  M-channel write data.
- d_srcA  input  5  read port A address.
- d_srcB  input  5  read port B address.
- d_rvalA  output  32  read port A data (combinational).
- d_rvalB  output  32  read port B data (combinational).
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  debug read data: stored value only, never bypassed.
- wr_count  output  CNT_W  number of committed register updates since reset.

Behaviour:
- Storage: registers 1..31, 32 bits each. Register 0 has no storage and always reads 0.
- Reset: one clock is synchronous, reset is synchronous and active-high (clock port clk, reset port rst).
  - At a rising edge with rst=1: registers 1..31 become 0 and wr_count becomes 0.
  - Writes presented in that cycle are discarded.
  - While rst=1, d_rvalA, d_rvalB and dbg_data read 0.
  - Reset asserted mid-stream takes priority over any pending write.
- Write enable per channel: dst != 0 and rst=0. Data is committed at the rising edge and is visible in storage in the next cycle.
- Dual-write conflict (W_dstE == W_dstM != 0): the M channel wins; the register takes W_valM.
- Read mux, evaluated per port, in priority order:
  1. src == 0 gives 0.
  2. BYPASS=1, rst=0 and src == W_dstM gives W_valM.
  3. BYPASS=1, rst=0 and src == W_dstE gives W_valE.
  4. Otherwise the stored value.
  - The M-before-E priority matches the conflict rule, so a bypassed value always equals the value stored next cycle.
- Latency: reads are zero-cycle (combinational). With BYPASS=0, write-to-read latency is one cycle.
- wr_count:
  - Per cycle (rst=0), adds the number of distinct registers updated: 0, 1, or 2.
  - Equal nonzero destinations count as 1.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - The add and the saturation check are done in CNT_W+1 bits.
- No X propagation: every output is fully defined for all input combinations after the first reset.
- Before the first reset, contents are undefined; the bench must reset first.

Test Plan:
- Reset, then read every index on both ports -> all 0; wr_count = 0.
- W_dstE=5/W_valE=0x1234_5678 for one cycle, then d_srcA=5 -> 0x1234_5678; wr_count = 1. Same cycle with BYPASS=1 and d_srcB=5 -> 0x1234_5678 combinationally, while dbg_addr=5 still returns the old value 0.
- W_dstE=W_dstM=9, W_valE=0xAAAA_AAAA, W_valM=0x5555_5555 -> d_rvalA (src 9) bypass gives 0x5555_5555; next cycle stored 0x5555_5555; wr_count increments by 1. Then distinct dst 3 and 4 -> wr_count increments by 2.
- Writes to register 0 on both channels with W_valE=W_valM=0xFFFF_FFFF -> d_srcA=0 reads 0; wr_count unchanged.
- Load r7=0x0000_00FF, then assert rst in the same cycle as W_dstM=7/W_valM=0xDEAD_BEEF -> outputs 0 during reset; after deassert r7 reads 0 and wr_count = 0.
- CNT_W=3, perform 9 single writes -> wr_count sticks at 7. A dual write at count 6 -> 7, not 0.
